// File: rtl/kamacore_pipeline_ctrl.sv
// Hazard / pipeline-control unit: load-use, EX/MEM busy stalls and branch redirects.
// Optional perf counters enabled by defining KAMACORE_PIPE_PERF_CNT_EN.
module kamacore_pipeline_ctrl #(
  parameter int NUM_STAGES       = 5,
  parameter int EX_STAGE         = 2,
  parameter int MEM_STAGE        = 3,
  parameter int LOAD_USE_PENALTY = 1,
  parameter int REG_ADDR_WIDTH   = 5,
  parameter int CNT_WIDTH        = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_a,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_a,
  input  logic                      id_rs1_used,
  input  logic                      id_rs2_used,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd_a,
  input  logic                      ex_rd_we,
  input  logic                      ex_is_load,
  input  logic                      ex_busy,
  input  logic                      mem_busy,
  input  logic                      branch_taken,
  output logic                      pc_hold,
  output logic [NUM_STAGES-2:0]     hold,
  output logic [NUM_STAGES-2:0]     flush,
  output logic                      redirect_accept,
  output logic [CNT_WIDTH-1:0]      stall_cycles,
  output logic [CNT_WIDTH-1:0]      flush_count
);

  localparam int NR = NUM_STAGES - 1;
  localparam logic [2:0] LU_INIT = 3'(LOAD_USE_PENALTY - 1);

  typedef enum logic {RUN, LU_STALL} state_t;

  state_t     state;
  logic [2:0] lu_cnt;
  logic       lu_hit;
  logic       any_busy;
  logic       redir;
  logic       id_stall;

  // Bits 0..s-1 set: registers upstream of stage s.
  function automatic logic [NR-1:0] below_mask(input int s);
    logic [NR-1:0] m;
    m = '0;
    for (int k = 0; k < NR; k++)
      if (k < s) m[k] = 1'b1;
    return m;
  endfunction

  function automatic logic [NR-1:0] at_mask(input int s);
    logic [NR-1:0] m;
    m = '0;
    for (int k = 0; k < NR; k++)
      if (k == s) m[k] = 1'b1;
    return m;
  endfunction

  always_comb begin
    lu_hit   = ex_is_load && ex_rd_we && (ex_rd_a != '0) &&
               ((id_rs1_used && (id_rs1_a == ex_rd_a)) ||
                (id_rs2_used && (id_rs2_a == ex_rd_a)));
    any_busy = mem_busy || ex_busy;
    redir    = !any_busy && branch_taken;
    // LU_STALL keeps stalling ID without re-checking the dependency
    id_stall = !any_busy && !branch_taken && ((state == LU_STALL) || lu_hit);
  end

  always_comb begin
    pc_hold         = 1'b0;
    hold            = '0;
    flush           = '0;
    redirect_accept = 1'b0;
    if (rst) begin
      pc_hold = 1'b1;
      flush   = '1;
    end else if (mem_busy) begin
      pc_hold = 1'b1;
      hold    = below_mask(MEM_STAGE);
      flush   = at_mask(MEM_STAGE);
    end else if (ex_busy) begin
      pc_hold = 1'b1;
      hold    = below_mask(EX_STAGE);
      flush   = at_mask(EX_STAGE);
    end else if (redir) begin
      redirect_accept = 1'b1;
      flush           = below_mask(EX_STAGE);
    end else if (id_stall) begin
      pc_hold = 1'b1;
      hold    = below_mask(1);
      flush   = at_mask(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      lu_cnt <= 3'd0;
    end else begin
      case (state)
        RUN: begin
          if (id_stall && (LOAD_USE_PENALTY > 1)) begin
            state  <= LU_STALL;
            lu_cnt <= LU_INIT;
          end
        end
        LU_STALL: begin
          if (redir) begin
            state  <= RUN;
            lu_cnt <= 3'd0;
          end else if (id_stall) begin
            if (lu_cnt == 3'd1) state <= RUN;
            lu_cnt <= lu_cnt - 3'd1;
          end
        end
        default: begin
          state  <= RUN;
          lu_cnt <= 3'd0;
        end
      endcase
    end
  end

`ifdef KAMACORE_PIPE_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] stall_cnt_q;
  logic [CNT_WIDTH-1:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (pc_hold)         stall_cnt_q <= stall_cnt_q + 1'b1;
      if (redirect_accept) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_count  = flush_cnt_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_kamacore_pipeline_ctrl.sv
// Bench for kamacore_pipeline_ctrl: two instances (penalty 1 and 3) on shared stimulus,
// checked every cycle against a remaining-bubble model plus literal expectations.
module tb_kamacore_pipeline_ctrl;

  localparam int NS  = 5;
  localparam int NR  = NS - 1;
  localparam int EX  = 2;
  localparam int MEM = 3;
  localparam int AW  = 5;
  localparam int CW  = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] id_rs1_a, id_rs2_a, ex_rd_a;
  logic          id_rs1_used, id_rs2_used, ex_rd_we, ex_is_load;
  logic          ex_busy, mem_busy, branch_taken;

  logic          ph1, ph3, ra1, ra3;
  logic [NR-1:0] h1, h3, f1, f3;
  logic [CW-1:0] sc1_d, sc3_d, fc1_d, fc3_d;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  kamacore_pipeline_ctrl #(
    .NUM_STAGES(NS), .EX_STAGE(EX), .MEM_STAGE(MEM),
    .LOAD_USE_PENALTY(1), .REG_ADDR_WIDTH(AW), .CNT_WIDTH(CW)
  ) dut1 (
    .clk(clk), .rst(rst),
    .id_rs1_a(id_rs1_a), .id_rs2_a(id_rs2_a),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd_a(ex_rd_a), .ex_rd_we(ex_rd_we), .ex_is_load(ex_is_load),
    .ex_busy(ex_busy), .mem_busy(mem_busy), .branch_taken(branch_taken),
    .pc_hold(ph1), .hold(h1), .flush(f1), .redirect_accept(ra1),
    .stall_cycles(sc1_d), .flush_count(fc1_d)
  );

  kamacore_pipeline_ctrl #(
    .NUM_STAGES(NS), .EX_STAGE(EX), .MEM_STAGE(MEM),
    .LOAD_USE_PENALTY(3), .REG_ADDR_WIDTH(AW), .CNT_WIDTH(CW)
  ) dut3 (
    .clk(clk), .rst(rst),
    .id_rs1_a(id_rs1_a), .id_rs2_a(id_rs2_a),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd_a(ex_rd_a), .ex_rd_we(ex_rd_we), .ex_is_load(ex_is_load),
    .ex_busy(ex_busy), .mem_busy(mem_busy), .branch_taken(branch_taken),
    .pc_hold(ph3), .hold(h3), .flush(f3), .redirect_accept(ra3),
    .stall_cycles(sc3_d), .flush_count(fc3_d)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: rem = bubbles still owed to ID after the current cycle's decision.
  typedef struct packed {
    logic          ph;
    logic [NR-1:0] h;
    logic [NR-1:0] f;
    logic          ra;
  } out_t;

  int            rem1 = 0, rem3 = 0;
  logic [CW-1:0] msc1 = '0, msc3 = '0, mfc1 = '0, mfc3 = '0;

  function automatic logic dep_hit();
    return ex_is_load && ex_rd_we && (ex_rd_a != 0) &&
           ((id_rs1_used && id_rs1_a == ex_rd_a) || (id_rs2_used && id_rs2_a == ex_rd_a));
  endfunction

  function automatic out_t stall_at(input int s);
    out_t o;
    o.ph = 1'b1;
    o.h  = NR'((1 << s) - 1);
    o.f  = NR'(1 << s);
    o.ra = 1'b0;
    return o;
  endfunction

  function automatic out_t model_out(input int rem);
    out_t o;
    o = '0;
    if (rst) begin
      o.ph = 1'b1;
      o.f  = '1;
    end else if (mem_busy)     o = stall_at(MEM);
    else if (ex_busy)          o = stall_at(EX);
    else if (branch_taken) begin
      o.ra = 1'b1;
      o.f  = NR'((1 << EX) - 1);
    end else if (rem > 0 || dep_hit()) o = stall_at(1);
    return o;
  endfunction

  function automatic int next_rem(input int rem, input int pen);
    if (rst)                  return 0;
    if (mem_busy || ex_busy)  return rem;
    if (branch_taken)         return 0;
    if (rem > 0)              return rem - 1;
    if (dep_hit())            return pen - 1;
    return rem;
  endfunction

  always @(negedge clk) begin
    out_t e1, e3;
    logic [CW-1:0] es1, es3, ef1, ef3;
    e1 = model_out(rem1);
    e3 = model_out(rem3);
`ifdef KAMACORE_PIPE_PERF_CNT_EN
    es1 = msc1; es3 = msc3; ef1 = mfc1; ef3 = mfc3;
`else
    es1 = '0; es3 = '0; ef1 = '0; ef3 = '0;
`endif
    chk("p1_pc_hold", 64'(ph1), 64'(e1.ph));
    chk("p1_hold",    64'(h1),  64'(e1.h));
    chk("p1_flush",   64'(f1),  64'(e1.f));
    chk("p1_redir",   64'(ra1), 64'(e1.ra));
    chk("p3_pc_hold", 64'(ph3), 64'(e3.ph));
    chk("p3_hold",    64'(h3),  64'(e3.h));
    chk("p3_flush",   64'(f3),  64'(e3.f));
    chk("p3_redir",   64'(ra3), 64'(e3.ra));
    chk("p1_stall_cycles", 64'(sc1_d), 64'(es1));
    chk("p3_stall_cycles", 64'(sc3_d), 64'(es3));
    chk("p1_flush_count",  64'(fc1_d), 64'(ef1));
    chk("p3_flush_count",  64'(fc3_d), 64'(ef3));
  end

  always @(posedge clk) begin
    out_t o1, o3;
    o1 = model_out(rem1);
    o3 = model_out(rem3);
    if (rst) begin
      msc1 = '0; msc3 = '0; mfc1 = '0; mfc3 = '0;
    end else begin
      msc1 = msc1 + CW'(o1.ph); msc3 = msc3 + CW'(o3.ph);
      mfc1 = mfc1 + CW'(o1.ra); mfc3 = mfc3 + CW'(o3.ra);
    end
    rem1 = next_rem(rem1, 1);
    rem3 = next_rem(rem3, 3);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1_a = '0; id_rs2_a = '0; ex_rd_a = '0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_rd_we = 1'b0; ex_is_load = 1'b0;
    ex_busy = 1'b0; mem_busy = 1'b0; branch_taken = 1'b0;
  endtask

  task automatic set_lu(input logic [AW-1:0] rd, input logic [AW-1:0] r1, input logic u1,
                        input logic [AW-1:0] r2, input logic u2);
    idle();
    ex_is_load = 1'b1; ex_rd_we = 1'b1; ex_rd_a = rd;
    id_rs1_a = r1; id_rs1_used = u1;
    id_rs2_a = r2; id_rs2_used = u2;
  endtask

  int n3;

  initial begin
    rst = 1'b1;
    idle();
    cyc(); cyc();
    @(negedge clk);
    chk("rst_pc_hold", 64'(ph1), 64'd1);
    chk("rst_hold",    64'(h1),  64'h0);
    chk("rst_flush",   64'(f3),  64'hF);
    chk("rst_redir",   64'(ra3), 64'd0);

    cyc(); rst = 1'b0;
    @(negedge clk);
    chk("idle_pc_hold", 64'(ph1), 64'd0);

    // load x5 in EX, ID reads rs1=x5
    cyc(); set_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    @(negedge clk);
    chk("lu1_pc_hold", 64'(ph1), 64'd1);
    chk("lu1_hold",    64'(h1),  64'h1);
    chk("lu1_flush",   64'(f1),  64'h2);
    cyc(); idle();
    @(negedge clk);
    chk("lu1_after_pc_hold", 64'(ph1), 64'd0);
    chk("lu1_after_flush",   64'(f1),  64'h0);
    chk("lu3_c2_pc_hold",    64'(ph3), 64'd1);
    cyc();
    @(negedge clk);
    chk("lu3_c3_pc_hold", 64'(ph3), 64'd1);
    cyc();
    @(negedge clk);
    chk("lu3_c4_pc_hold", 64'(ph3), 64'd0);

    // penalty 3 with mem_busy injected in the 2nd stall cycle for 2 cycles
    n3 = 0;
    cyc(); set_lu(5'd7, 5'd7, 1'b1, 5'd0, 1'b0);
    @(negedge clk); n3 += int'(ph3);
    cyc(); idle(); mem_busy = 1'b1;
    @(negedge clk); n3 += int'(ph3);
    chk("mb_hold",  64'(h3), 64'h7);
    chk("mb_flush", 64'(f3), 64'h8);
    cyc();
    @(negedge clk); n3 += int'(ph3);
    for (int i = 0; i < 3; i++) begin
      cyc(); idle();
      @(negedge clk); n3 += int'(ph3);
    end
    chk("mb_total_stalls", 64'(n3), 64'd5);

    // branch redirect, then held off by mem_busy
    cyc(); idle(); branch_taken = 1'b1;
    @(negedge clk);
    chk("br_redir",   64'(ra1), 64'd1);
    chk("br_flush",   64'(f1),  64'h3);
    chk("br_pc_hold", 64'(ph1), 64'd0);
    chk("br_hold",    64'(h1),  64'h0);
    for (int i = 0; i < 2; i++) begin
      cyc(); branch_taken = 1'b1; mem_busy = 1'b1;
      @(negedge clk);
      chk("br_mb_redir", 64'(ra1), 64'd0);
    end
    cyc(); mem_busy = 1'b0;
    @(negedge clk);
    chk("br_after_mb_redir", 64'(ra1), 64'd1);
    cyc(); idle();

    // x0 destination, and rs2 match while rs2 unused
    cyc(); set_lu(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
    @(negedge clk);
    chk("x0_pc_hold", 64'(ph3), 64'd0);
    cyc(); set_lu(5'd5, 5'd3, 1'b1, 5'd5, 1'b0);
    @(negedge clk);
    chk("rs2_unused_pc_hold", 64'(ph1), 64'd0);
    cyc(); set_lu(5'd5, 5'd3, 1'b1, 5'd5, 1'b1);
    @(negedge clk);
    chk("rs2_used_flush", 64'(f1), 64'h2);
    for (int i = 0; i < 3; i++) cyc();
    idle();

    // ex_busy outranks a pending branch
    cyc(); idle(); ex_busy = 1'b1; branch_taken = 1'b1;
    @(negedge clk);
    chk("exb_hold",  64'(h1),  64'h3);
    chk("exb_flush", 64'(f1),  64'h4);
    chk("exb_redir", 64'(ra1), 64'd0);
    cyc(); idle();

    // branch accepted in the 2nd cycle of a penalty-3 stall
    cyc(); set_lu(5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
    cyc(); idle(); branch_taken = 1'b1;
    @(negedge clk);
    chk("lu_br_redir", 64'(ra3), 64'd1);
    cyc(); idle();
    @(negedge clk);
    chk("lu_br_after_pc_hold", 64'(ph3), 64'd0);

    // reset in the middle of a penalty-3 stall
    cyc(); set_lu(5'd4, 5'd0, 1'b0, 5'd4, 1'b1);
    cyc(); idle(); rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_flush", 64'(f3), 64'hF);
    cyc(); rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_after_pc_hold", 64'(ph3), 64'd0);
    cyc(); set_lu(5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(); idle();
    end
    cyc(); cyc();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
